// File: rtl/comb_bank_tdm_if.sv
// comb_bank_tdm_if: sample, config and status bundle of the time-multiplexed comb bank
interface comb_bank_tdm_if #(
  parameter int WORD = 32,
  parameter int KW   = 2,
  parameter int TW   = 4
);
  logic [WORD-1:0] in;
  logic            in_valid;
  logic            cfg_we;
  logic [KW-1:0]   cfg_idx;
  logic [TW-1:0]   cfg_tau;
  logic [WORD-1:0] cfg_gain;
  logic [WORD-1:0] out;
  logic            out_valid;
  logic            busy;
  logic            overrun;
  modport master (
    output in, in_valid, cfg_we, cfg_idx, cfg_tau, cfg_gain,
    input  out, out_valid, busy, overrun
  );
  modport slave (
    input  in, in_valid, cfg_we, cfg_idx, cfg_tau, cfg_gain,
    output out, out_valid, busy, overrun
  );
endinterface

// File: rtl/comb_bank_tdm.sv
// comb_bank_tdm: N feedback combs sharing one datapath and one delay RAM, output is their saturated average
`ifndef FIXED_POINT
`define FIXED_POINT 8
`endif
`ifndef MAX_FILTER_FIFO_LENGTH
`define MAX_FILTER_FIFO_LENGTH 1024
`endif
module comb_bank_tdm #(
  parameter int WIDTH   = 24,
  parameter int N_COMBS = 4,
  parameter int MAXLEN  = `MAX_FILTER_FIFO_LENGTH,
  parameter int FRAC    = `FIXED_POINT
) (
  input logic clk,
  input logic rst,
  comb_bank_tdm_if.slave bus
);
  localparam int WORD  = WIDTH + FRAC;
  localparam int KW    = N_COMBS > 1 ? $clog2(N_COMBS) : 1;
  localparam int TW    = $clog2(MAXLEN);
  localparam int SH    = $clog2(N_COMBS);
  localparam int DEPTH = N_COMBS * MAXLEN;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = 2 * WORD;
  localparam int XW    = PW + 1;
  localparam int AC    = WORD + 4;
  localparam logic signed [XW-1:0] MAXV = {{(WORD+2){1'b0}}, {(WORD-1){1'b1}}};
  localparam logic signed [XW-1:0] MINV = ~MAXV;

  typedef enum logic [2:0] {CLEAR, IDLE, RD, MUL, WR, OUT} state_t;

  function automatic logic [WORD-1:0] sat(input logic signed [XW-1:0] x);
    return x > MAXV ? MAXV[WORD-1:0] : x < MINV ? MINV[WORD-1:0] : x[WORD-1:0];
  endfunction

  state_t                 r_state, w_next;
  logic signed [WORD-1:0] r_mem [DEPTH];
  logic signed [WORD-1:0] r_d, r_in, r_y;
  logic signed [AC-1:0]   r_acc;
  logic [KW-1:0]          r_k;
  logic [TW-1:0]          r_wptr;
  logic [AW-1:0]          r_clr;
  logic [TW-1:0]          r_tau [N_COMBS];
  logic [TW-1:0]          r_sh_tau [N_COMBS];
  logic signed [WORD-1:0] r_g [N_COMBS];
  logic signed [WORD-1:0] r_sh_g [N_COMBS];
  logic [WORD-1:0]        r_out;
  logic                   r_out_valid, r_overrun;

  logic                   w_last_k, w_we;
  logic [TW-1:0]          w_off;
  logic [AW-1:0]          w_base, w_rd_addr, w_wr_addr;
  logic signed [WORD-1:0] w_wdata;
  logic signed [PW-1:0]   w_prod;
  logic signed [XW-1:0]   w_sum;
  logic signed [AC-1:0]   w_acc_n;

  assign w_last_k  = r_k == KW'(N_COMBS - 1);
  // TW-bit subtraction wraps inside the comb's own region
  assign w_off     = r_wptr - r_tau[r_k];
  assign w_base    = AW'(r_k) << TW;
  assign w_rd_addr = w_base + AW'(w_off);
  assign w_wr_addr = r_state == CLEAR ? r_clr : w_base + AW'(r_wptr);
  assign w_we      = r_state == CLEAR || r_state == WR;
  assign w_wdata   = r_state == CLEAR ? '0 : r_y;
  assign w_prod    = (PW'(r_d) * PW'(r_g[r_k])) >>> FRAC;
  assign w_sum     = XW'(w_prod) + XW'(r_in);
  assign w_acc_n   = r_acc + AC'(r_y);

  assign bus.out       = r_out;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_state != IDLE;
  assign bus.overrun   = r_overrun;

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_wr_addr] <= w_wdata;
    r_d <= r_mem[w_rd_addr];
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      CLEAR:   w_next = r_clr == AW'(DEPTH - 1) ? IDLE : CLEAR;
      IDLE:    w_next = bus.in_valid ? RD : IDLE;
      RD:      w_next = MUL;
      MUL:     w_next = WR;
      WR:      w_next = w_last_k ? OUT : RD;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= CLEAR;
      r_clr       <= '0;
      r_k         <= '0;
      r_wptr      <= '0;
      r_acc       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
      for (int i = 0; i < N_COMBS; i++) begin
        r_tau[i]    <= TW'(1);
        r_sh_tau[i] <= TW'(1);
        r_g[i]      <= '0;
        r_sh_g[i]   <= '0;
      end
    end else begin
      r_state     <= w_next;
      r_out_valid <= r_state == WR && w_last_k;
      if (r_state == CLEAR) r_clr <= r_clr + 1'b1;
      if (bus.in_valid && r_state != IDLE) r_overrun <= 1'b1;
      if (bus.cfg_we) begin
        r_sh_tau[bus.cfg_idx] <= bus.cfg_tau == '0 ? TW'(1) : bus.cfg_tau;
        r_sh_g[bus.cfg_idx]   <= bus.cfg_gain;
      end
      // live parameters only change at sample start
      if (r_state == IDLE && bus.in_valid) begin
        r_in  <= bus.in;
        r_k   <= '0;
        r_tau <= r_sh_tau;
        r_g   <= r_sh_g;
      end
      if (r_state == MUL) r_y <= sat(w_sum);
      if (r_state == WR) begin
        r_acc <= w_acc_n;
        r_k   <= r_k + 1'b1;
        if (w_last_k) r_out <= sat(XW'(w_acc_n >>> SH));
      end
      if (r_state == OUT) begin
        r_wptr <= r_wptr + 1'b1;
        r_acc  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_comb_bank_tdm.sv
// tb_comb_bank_tdm: directed vectors with a queue scoreboard checked by an independent output monitor
module tb_comb_bank_tdm;
  localparam int WORD = 32;
  localparam int N    = 4;
  localparam int ML   = 16;
  localparam int KW   = 2;
  localparam int TW   = 4;
  localparam logic [WORD-1:0] PMAX = 32'h7fff_ffff;
  localparam logic [WORD-1:0] NMAX = 32'h8000_0000;
  localparam logic [WORD-1:0] IMP_EXP [7] = '{32'd256, 32'd0, 32'd0, 32'd32, 32'd0, 32'd0, 32'd16};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [WORD-1:0] exp_q [$];

  comb_bank_tdm_if #(.WORD(WORD), .KW(KW), .TW(TW)) bus ();
  comb_bank_tdm #(.WIDTH(24), .N_COMBS(N), .MAXLEN(ML), .FRAC(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [WORD-1:0] act, input logic [WORD-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 2000) begin
      tick();
      n++;
    end
    if (bus.busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles", n);
    end
  endtask

  task automatic cfg(input int idx, input int tau, input logic [WORD-1:0] g);
    bus.cfg_we   = 1'b1;
    bus.cfg_idx  = KW'(idx);
    bus.cfg_tau  = TW'(tau);
    bus.cfg_gain = g;
    tick();
    bus.cfg_we   = 1'b0;
  endtask

  task automatic send(input logic [WORD-1:0] x, input logic [WORD-1:0] e);
    bus.in       = x;
    bus.in_valid = 1'b1;
    exp_q.push_back(e);
    tick();
    bus.in_valid = 1'b0;
    wait_idle();
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %0h, expected no output", bus.out);
      end else begin
        check("out", bus.out, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int first;
    logic seen;
    bus.in = '0; bus.in_valid = 1'b0; bus.cfg_we = 1'b0;
    bus.cfg_idx = '0; bus.cfg_tau = '0; bus.cfg_gain = '0;

    do_reset();
    check("rst_busy", bus.busy, 1);
    check("rst_out", bus.out, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_overrun", bus.overrun, 0);
    n = 0;
    while (bus.busy && n < 1000) begin
      n++;
      tick();
    end
    check("clear_cycles", n, N * ML);

    bus.in = 32'h300; bus.in_valid = 1'b1;
    exp_q.push_back(32'h300);
    tick();
    first = 0;
    for (int c = 1; c <= 14; c++) begin
      bus.in_valid = c == 5;
      if (bus.out_valid && first == 0) first = c;
      if (c == 13) check("busy_high_13", bus.busy, 1);
      if (c == 14) check("busy_low_14", bus.busy, 0);
      tick();
    end
    bus.in_valid = 1'b0;
    check("latency", first, 13);
    check("overrun_set", bus.overrun, 1);
    send(32'h500, 32'h500);
    check("overrun_sticky", bus.overrun, 1);

    do_reset();
    check("overrun_cleared", bus.overrun, 0);
    wait_idle();
    cfg(0, 3, 32'h80);
    for (int i = 0; i < 7; i++) send(i == 0 ? 32'd256 : 32'd0, IMP_EXP[i]);

    do_reset();
    wait_idle();
    cfg(0, 0, 32'h100);
    send(32'd256, 32'd256);
    bus.in = '0; bus.in_valid = 1'b1;
    exp_q.push_back(32'd64);
    tick();
    bus.in_valid = 1'b0;
    tick();
    cfg(0, 0, 32'h80);
    wait_idle();
    send(32'd0, 32'd32);

    do_reset();
    wait_idle();
    for (int i = 0; i < N; i++) cfg(i, 1, 32'd253);
    for (int i = 0; i < 4; i++) send(PMAX, PMAX);
    do_reset();
    wait_idle();
    for (int i = 0; i < N; i++) cfg(i, 1, 32'd253);
    for (int i = 0; i < 4; i++) send(NMAX, NMAX);

    bus.in = 32'h7000; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("clear_restart", bus.busy, 1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid) seen = 1'b1;
      tick();
    end
    check("no_out_after_rst", seen, 0);
    wait_idle();
    cfg(0, 1, 32'h100);
    cfg(1, 5, 32'h100);
    cfg(2, 9, 32'h100);
    cfg(3, 15, 32'h100);
    for (int i = 0; i < ML; i++) send(32'd0, 32'd0);

    tick();
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
